bch_input_buffer: RTL and testbench

BCH_INPUT_BUFFER -- requirements
Module: bch_input_buffer

---
 rtl/bch_input_buffer.sv | 129 ++++++++++++
 tb/tb_bch_input_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_input_buffer.sv
// Serial BCH codeword input buffer: writes incoming bits into one of two RAM
// ping-pong buffers and hands completed codewords to the decision stage.
module bch_input_buffer #(
    parameter int m = 4,
    parameter int n = 15
) (
    input  logic         iclk,
    input  logic         ireset,
    input  logic         iclkena,
    input  logic         isop,
    input  logic         ival,
    input  logic         ieop,
    input  logic         idat,
    input  logic         ifree,
    output logic         ordy,
    output logic         owrite,
    output logic [m-1:0] owaddr,
    output logic         owptr,
    output logic         owdat,
    output logic         odata_val,
    output logic         odata_ptr,
    output logic         oerr,
    output logic         odbg_state
);

    typedef logic [m-1:0] data_t;
    typedef logic         ptr_t;
    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t     state;
    data_t      cnt;
    ptr_t       wptr;
    ptr_t       done_ptr;
    logic [1:0] used;
    logic       done_d;

    logic       wr_en;
    data_t      wr_addr;
    logic       last_bit;
    logic       complete;
    logic       frame_err;
    logic       free_ok;

    // Input handshake: a bit is taken when ival=1; a frame may only start when ordy=1.
    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = '0;
        last_bit  = 1'b0;
        complete  = 1'b0;
        frame_err = 1'b0;
        if (state == IDLE) begin
            wr_en = ival && isop && ordy;
        end else if (ival) begin
            wr_en = 1'b1;
            if (isop) begin
                frame_err = 1'b1;
            end else begin
                wr_addr   = cnt;
                last_bit  = (cnt == data_t'(n - 1));
                complete  = last_bit && ieop;
                // eop before the last bit, or last bit without eop
                frame_err = last_bit != ieop;
            end
        end
    end

    assign free_ok    = ifree && (used != 2'd0);
    assign ordy       = (used != 2'd2);
    assign odbg_state = (state == FILL);

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state     <= IDLE;
            cnt       <= '0;
            wptr      <= 1'b0;
            used      <= 2'd0;
            done_d    <= 1'b0;
            done_ptr  <= 1'b0;
            owrite    <= 1'b0;
            owaddr    <= '0;
            owptr     <= 1'b0;
            owdat     <= 1'b0;
            odata_val <= 1'b0;
            odata_ptr <= 1'b0;
            oerr      <= 1'b0;
        end else if (iclkena) begin
            owrite <= wr_en;
            if (wr_en) begin
                owaddr <= wr_addr;
                owptr  <= wptr;
                owdat  <= idat;
            end
            oerr      <= frame_err;
            done_d    <= complete;
            odata_val <= done_d;
            odata_ptr <= done_ptr;
            if (complete) begin
                done_ptr <= wptr;
                wptr     <= ~wptr;
            end
            if (complete && !free_ok)
                used <= used + 2'd1;
            else if (!complete && free_ok)
                used <= used - 2'd1;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        state <= FILL;
                        cnt   <= data_t'(1);
                    end
                end
                FILL: begin
                    if (ival) begin
                        if (isop) begin
                            cnt <= data_t'(1);
                        end else if (ieop || last_bit) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + data_t'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_input_buffer.sv
// Randomized frame-level bench for bch_input_buffer: expected RAM writes, codeword
// reports and error pulses are derived per frame and matched against the outputs.
module tb_bch_input_buffer;
    localparam int M = 4;
    localparam int N = 15;

    logic         iclk = 1'b0;
    logic         ireset = 1'b0;
    logic         iclkena = 1'b0;
    logic         isop = 1'b0;
    logic         ival = 1'b0;
    logic         ieop = 1'b0;
    logic         idat = 1'b0;
    logic         ifree = 1'b0;
    logic         ordy;
    logic         owrite;
    logic [M-1:0] owaddr;
    logic         owptr;
    logic         owdat;
    logic         odata_val;
    logic         odata_ptr;
    logic         oerr;
    logic         odbg_state;

    bch_input_buffer #(.m(M), .n(N)) dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .iclkena    (iclkena),
        .isop       (isop),
        .ival       (ival),
        .ieop       (ieop),
        .idat       (idat),
        .ifree      (ifree),
        .ordy       (ordy),
        .owrite     (owrite),
        .owaddr     (owaddr),
        .owptr      (owptr),
        .owdat      (owdat),
        .odata_val  (odata_val),
        .odata_ptr  (odata_ptr),
        .oerr       (oerr),
        .odbg_state (odbg_state)
    );

    // clock / reset
    always #5 iclk = ~iclk;

    int   cyc = 0;
    logic last_en = 1'b0;
    always @(posedge iclk) begin
        if (iclkena) cyc++;
        last_en = iclkena;
    end

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_wr_q[$];
    logic [31:0] exp_dv_q[$];
    logic [31:0] exp_err_q[$];

    int   m_used = 0;
    logic m_wptr = 1'b0;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // scoreboard: every output event must match the head of its expected queue
    always @(negedge iclk) begin
        if (last_en && ireset) begin
            if (owrite) begin
                if (exp_wr_q.size() == 0)
                    check_val("write_extra", {16'(cyc), 8'(owaddr), 6'b0, owptr, owdat}, 32'hffffffff);
                else
                    check_val("write", {16'(cyc), 8'(owaddr), 6'b0, owptr, owdat}, exp_wr_q.pop_front());
            end
            if (odata_val) begin
                if (exp_dv_q.size() == 0)
                    check_val("data_val_extra", {16'(cyc), 15'b0, odata_ptr}, 32'hffffffff);
                else
                    check_val("data_val", {16'(cyc), 15'b0, odata_ptr}, exp_dv_q.pop_front());
            end
            if (oerr) begin
                if (exp_err_q.size() == 0)
                    check_val("err_extra", 32'(cyc), 32'hffffffff);
                else
                    check_val("err", 32'(cyc), exp_err_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic quiet(input int cycles);
        repeat (cycles) begin
            @(negedge iclk);
            iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0; idat = 1'b0; ifree = 1'b0;
        end
    endtask

    task automatic drive_bit(input logic s, input logic e, input logic d, input logic f, output int tag);
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int i = 0; i < gaps; i++) begin
            @(negedge iclk);
            iclkena = ($urandom_range(0, 3) != 0);
            ival    = iclkena ? 1'b0 : 1'($urandom_range(0, 1));
            isop    = 1'($urandom_range(0, 1));
            ieop    = 1'($urandom_range(0, 1));
            idat    = 1'($urandom_range(0, 1));
            ifree   = 1'b0;
        end
        @(negedge iclk);
        iclkena = 1'b1; ival = 1'b1; isop = s; ieop = e; idat = d; ifree = f;
        tag = cyc + 1;
    endtask

    task automatic free_pulse();
        @(negedge iclk);
        iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0; ifree = 1'b1;
        @(negedge iclk);
        ifree = 1'b0;
        if (m_used > 0) m_used--;
        check_val("ordy_after_free", 32'(ordy), 32'(m_used != 2));
    endtask

    // kind: 0 good, 1 eop early at bit k, 2 no eop, 3 new sop at bit k
    task automatic send_frame(input int kind, input int k, input logic free_last);
        int   len;
        int   tag;
        int   addr;
        logic acc;
        logic ptr;
        logic d;
        logic s;
        logic e;
        logic complete;
        logic free_ok;
        len = (kind == 1) ? k + 1 : (kind == 3) ? k + N : N;
        acc = (m_used != 2);
        ptr = m_wptr;
        tag = 0;
        for (int j = 0; j < len; j++) begin
            s    = (j == 0) || (kind == 3 && j == k);
            e    = ((kind == 0 || kind == 3) && j == len - 1) || (kind == 1 && j == k);
            addr = (kind == 3 && j >= k) ? j - k : j;
            d    = 1'($urandom_range(0, 1));
            drive_bit(s, e, d, free_last && (j == len - 1), tag);
            if (acc) begin
                exp_wr_q.push_back({16'(tag), 8'(addr), 6'b0, ptr, d});
                if ((kind == 1 && j == k) || (kind == 2 && j == N - 1) || (kind == 3 && j == k))
                    exp_err_q.push_back(32'(tag));
            end
        end
        complete = acc && (kind == 0 || kind == 3);
        free_ok  = free_last && (m_used > 0);
        if (complete) begin
            exp_dv_q.push_back({16'(tag + 1), 15'b0, ptr});
            m_wptr = ~m_wptr;
        end
        m_used = m_used + int'(complete) - int'(free_ok);
        quiet(3);
        check_val("ordy_after_frame", 32'(ordy), 32'(m_used != 2));
        check_val("state_idle", 32'(odbg_state), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check_val({name, "_owrite"}, 32'(owrite), 32'd0);
        check_val({name, "_owaddr"}, 32'(owaddr), 32'd0);
        check_val({name, "_owptr"}, 32'(owptr), 32'd0);
        check_val({name, "_owdat"}, 32'(owdat), 32'd0);
        check_val({name, "_odata_val"}, 32'(odata_val), 32'd0);
        check_val({name, "_odata_ptr"}, 32'(odata_ptr), 32'd0);
        check_val({name, "_oerr"}, 32'(oerr), 32'd0);
        check_val({name, "_ordy"}, 32'(ordy), 32'd1);
        check_val({name, "_state"}, 32'(odbg_state), 32'd0);
    endtask

    initial begin
        int tag;
        int kind;

        ireset = 1'b0;
        repeat (3) @(negedge iclk);
        check_reset_outputs("reset");
        ireset = 1'b1;
        quiet(2);

        // single good frame, then fill both buffers
        send_frame(0, 0, 1'b0);
        send_frame(0, 0, 1'b0);
        send_frame(0, 0, 1'b0);
        free_pulse();
        send_frame(0, 0, 1'b0);
        free_pulse();
        free_pulse();

        // framing errors followed by good frames
        send_frame(1, 9, 1'b0);
        send_frame(0, 0, 1'b0);
        send_frame(3, 6, 1'b0);
        send_frame(2, 0, 1'b0);
        free_pulse();
        free_pulse();

        // release coincident with completion at one buffer used, then release when empty
        send_frame(0, 0, 1'b0);
        send_frame(0, 0, 1'b1);
        free_pulse();
        free_pulse();
        send_frame(0, 0, 1'b0);
        send_frame(0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            send_frame(kind, $urandom_range(1, 13), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) != 0) free_pulse();
        end

        // reset in the middle of a frame while the write pointer sits on buffer 1
        while (m_used == 2) free_pulse();
        if (m_wptr == 1'b0) send_frame(0, 0, 1'b0);
        while (m_used == 2) free_pulse();
        for (int j = 0; j < 7; j++) begin
            logic d;
            d = 1'($urandom_range(0, 1));
            drive_bit(j == 0, 1'b0, d, 1'b0, tag);
            exp_wr_q.push_back({16'(tag), 8'(j), 6'b0, m_wptr, d});
        end
        @(negedge iclk);
        #2;
        ireset = 1'b0;
        ival = 1'b0; isop = 1'b0; ieop = 1'b0; ifree = 1'b0;
        m_used = 0;
        m_wptr = 1'b0;
        repeat (2) @(negedge iclk);
        check_reset_outputs("mid_reset");
        ireset = 1'b1;
        quiet(2);
        send_frame(0, 0, 1'b0);
        quiet(4);

        check_val("writes_left", 32'(exp_wr_q.size()), 32'd0);
        check_val("data_val_left", 32'(exp_dv_q.size()), 32'd0);
        check_val("err_left", 32'(exp_err_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
